// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
// Fetch stage between synchronous instruction memory and decode. Owns the
// fetch PC, issues one word request per cycle while credit allows, buffers
// returned words with their PCs in a DEPTH-entry FIFO and presents the head
// to decode over valid/ready. A redirect flushes the FIFO and any in-flight
// response and restarts fetch at the word-aligned redirect address.
//
// Optional feature (macro FETCH_QUEUE_BYPASS_EN):
//   When defined, a response arriving while the FIFO is empty is presented to
//   decode combinationally in the same cycle and skips the FIFO if accepted.
//   When undefined, every response passes through the FIFO.
module instr_fetch_queue #(
  parameter int               ADDR_W   = 32,
  parameter int               WORD_W   = 32,
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic                         clk,
  input  logic                         aresetn,
  output logic [ADDR_W-1:0]            o_instr_req_addr,
  output logic                         o_instr_req_en,
  input  logic [WORD_W-1:0]            i_instr_res_data,
  input  logic                         i_redirect_en,
  input  logic [ADDR_W-1:0]            i_redirect_addr,
  output logic                         o_instr_valid,
  output logic [WORD_W-1:0]            o_instr_data,
  output logic [ADDR_W-1:0]            o_instr_pc,
  input  logic                         i_instr_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [CNT_W:0]   DEPTH_L  = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

  // Fetch state
  logic [ADDR_W-1:0] fetch_pc_r;
  logic              inflight_r;
  logic [ADDR_W-1:0] inflight_pc_r;

  // FIFO storage and bookkeeping
  logic [WORD_W-1:0] data_mem_r [DEPTH];
  logic [ADDR_W-1:0] pc_mem_r   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;

  // Combinational control
  logic [CNT_W:0]    credit_s;
  logic              req_en_s;
  logic              resp_ok_s;
  logic              fifo_nonempty_s;
  logic              bypass_s;
  logic              out_valid_s;
  logic              pop_s;
  logic              fifo_push_s;
  logic              fifo_pop_s;
  logic [WORD_W-1:0] out_data_s;
  logic [ADDR_W-1:0] out_pc_s;

  // Request credit: entries held plus the word still in flight must leave
  // room in the FIFO, so a push can never find it full.
  always_comb begin
    credit_s = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r};
    req_en_s = 1'b0;
    if (aresetn && !i_redirect_en && (credit_s < DEPTH_L)) begin
      req_en_s = 1'b1;
    end else begin
      req_en_s = 1'b0;
    end
  end

  // A response is kept only if no redirect is flushing this cycle. A redirect
  // in the request cycle already suppressed the request, so inflight_r is 0.
  always_comb begin
    resp_ok_s       = inflight_r && !i_redirect_en;
    fifo_nonempty_s = (count_r != {CNT_W{1'b0}});
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass_s        = resp_ok_s && !fifo_nonempty_s;
`else
    bypass_s        = 1'b0;
`endif
  end

  // Head selection: FIFO head when non-empty, bypassed response otherwise.
  // Data and PC read as zero when nothing is valid.
  always_comb begin
    out_valid_s = fifo_nonempty_s || bypass_s;
    out_data_s  = {WORD_W{1'b0}};
    out_pc_s    = {ADDR_W{1'b0}};
    if (fifo_nonempty_s) begin
      out_data_s = data_mem_r[rd_ptr_r];
      out_pc_s   = pc_mem_r[rd_ptr_r];
    end else if (bypass_s) begin
      out_data_s = i_instr_res_data;
      out_pc_s   = inflight_pc_r;
    end else begin
      out_data_s = {WORD_W{1'b0}};
      out_pc_s   = {ADDR_W{1'b0}};
    end
  end

  // Handshake and FIFO push/pop decode. A bypassed word taken by decode this
  // cycle never enters the FIFO.
  always_comb begin
    pop_s       = out_valid_s && i_instr_ready;
    fifo_pop_s  = pop_s && fifo_nonempty_s;
    fifo_push_s = 1'b0;
    if (resp_ok_s) begin
      if (bypass_s && i_instr_ready) begin
        fifo_push_s = 1'b0;
      end else begin
        fifo_push_s = 1'b1;
      end
    end else begin
      fifo_push_s = 1'b0;
    end
  end

  // Fetch PC and in-flight tracking; redirect realigns the PC to a word.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      fetch_pc_r    <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= {ADDR_W{1'b0}};
    end else begin
      inflight_r <= req_en_s;
      if (i_redirect_en) begin
        fetch_pc_r <= {i_redirect_addr[ADDR_W-1:2], 2'b00};
      end else if (req_en_s) begin
        fetch_pc_r    <= fetch_pc_r + PC_STEP;
        inflight_pc_r <= fetch_pc_r;
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_r[i] <= {WORD_W{1'b0}};
        pc_mem_r[i]   <= {ADDR_W{1'b0}};
      end
    end else begin
      if (fifo_push_s) begin
        data_mem_r[wr_ptr_r] <= i_instr_res_data;
        pc_mem_r[wr_ptr_r]   <= inflight_pc_r;
      end else begin
        data_mem_r[wr_ptr_r] <= data_mem_r[wr_ptr_r];
        pc_mem_r[wr_ptr_r]   <= pc_mem_r[wr_ptr_r];
      end
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue after any
  // same-cycle pop has completed its handshake.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (i_redirect_en) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (fifo_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (fifo_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({fifo_push_s, fifo_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Output drive.
  always_comb begin
    o_instr_req_addr = fetch_pc_r;
    o_instr_req_en   = req_en_s;
    o_instr_valid    = out_valid_s;
    o_instr_data     = out_data_s;
    o_instr_pc       = out_pc_s;
    o_count          = count_r;
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue (default build).
// Instruction memory model: word at byte address A holds A >> 2.
module tb_instr_fetch_queue;

  logic        clk;
  logic        aresetn;
  logic [31:0] req_addr;
  logic        req_en;
  logic [31:0] res_data;
  logic        redirect_en;
  logic [31:0] redirect_addr;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  instr_fetch_queue #(
    .ADDR_W(32), .WORD_W(32), .DEPTH(4), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk              (clk),
    .aresetn          (aresetn),
    .o_instr_req_addr (req_addr),
    .o_instr_req_en   (req_en),
    .i_instr_res_data (res_data),
    .i_redirect_en    (redirect_en),
    .i_redirect_addr  (redirect_addr),
    .o_instr_valid    (instr_valid),
    .o_instr_data     (instr_data),
    .o_instr_pc       (instr_pc),
    .i_instr_ready    (instr_ready),
    .o_count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: data returns the cycle after a request.
  always @(posedge clk) begin
    if (req_en) res_data <= req_addr >> 2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Hold reset across one negedge, release it at the next, settle.
  task automatic do_reset(input logic rdy);
    aresetn     = 1'b0;
    instr_ready = rdy;
    redirect_en = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    #1;
  endtask

  initial begin
    aresetn       = 1'b0;
    instr_ready   = 1'b1;
    redirect_en   = 1'b0;
    redirect_addr = 32'h0;
    res_data      = 32'h0;

    // ---- Reset state ----
    @(negedge clk); #1;
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_req_en", {31'd0, req_en}, 32'd0);
    check("rst_data", instr_data, 32'd0);
    check("rst_pc", instr_pc, 32'd0);
    check("rst_req_addr", req_addr, 32'h0);

    // ---- Test 1: streaming with ready=1 ----
    aresetn = 1'b1; #1;
    check("t1_n0_en", {31'd0, req_en}, 32'd1);
    check("t1_n0_addr", req_addr, 32'h0);
    tick();
    check("t1_n1_addr", req_addr, 32'h4);
    check("t1_n1_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    check("t1_n2_valid", {31'd0, instr_valid}, 32'd1);
    check("t1_n2_pc", instr_pc, 32'h0);
    check("t1_n2_data", instr_data, 32'h0);
    check("t1_n2_addr", req_addr, 32'h8);
    tick();
    check("t1_n3_pc", instr_pc, 32'h4);
    check("t1_n3_data", instr_data, 32'h1);
    tick();
    check("t1_n4_pc", instr_pc, 32'h8);
    check("t1_n4_data", instr_data, 32'h2);

    // ---- Test 4: redirect while popping pc 0x8 ----
    redirect_en = 1'b1; redirect_addr = 32'h200; #1;
    check("t4_redir_en", {31'd0, req_en}, 32'd0);
    @(negedge clk);
    redirect_en = 1'b0; #1;
    check("t4_valid", {31'd0, instr_valid}, 32'd0);
    check("t4_count", {29'd0, count}, 32'd0);
    check("t4_addr", req_addr, 32'h200);
    check("t4_en", {31'd0, req_en}, 32'd1);
    tick();
    check("t4_n6_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    check("t4_n7_pc", instr_pc, 32'h200);
    check("t4_n7_data", instr_data, 32'h80);

    // ---- Test 5: unaligned redirect and PC wrap ----
    redirect_en = 1'b1; redirect_addr = 32'h103;
    @(negedge clk);
    redirect_en = 1'b0; #1;
    check("t5_align_addr", req_addr, 32'h100);
    tick();
    tick();
    check("t5_align_pc", instr_pc, 32'h100);
    check("t5_align_data", instr_data, 32'h40);
    redirect_en = 1'b1; redirect_addr = 32'hFFFF_FFFF;
    @(negedge clk);
    redirect_en = 1'b0; #1;
    check("t5_wrap_addr0", req_addr, 32'hFFFF_FFFC);
    tick();
    check("t5_wrap_addr1", req_addr, 32'h0);
    tick();
    check("t5_wrap_pc0", instr_pc, 32'hFFFF_FFFC);
    check("t5_wrap_data0", instr_data, 32'h3FFF_FFFF);
    tick();
    check("t5_wrap_pc1", instr_pc, 32'h0);

    // ---- Test 2: backpressure fills the queue ----
    do_reset(1'b0);
    check("t2_n0_addr", req_addr, 32'h0);
    tick(); tick(); tick();
    check("t2_n3_addr", req_addr, 32'hC);
    check("t2_n3_en", {31'd0, req_en}, 32'd1);
    tick();
    check("t2_n4_en", {31'd0, req_en}, 32'd0);
    check("t2_n4_count", {29'd0, count}, 32'd3);
    tick();
    check("t2_n5_count", {29'd0, count}, 32'd4);
    check("t2_n5_en", {31'd0, req_en}, 32'd0);
    check("t2_n5_pc", instr_pc, 32'h0);
    check("t2_n5_addr", req_addr, 32'h10);
    tick();
    check("t2_n6_hold_pc", instr_pc, 32'h0);
    check("t2_n6_hold_valid", {31'd0, instr_valid}, 32'd1);
    instr_ready = 1'b1;
    tick();
    check("t2_n7_pc", instr_pc, 32'h4);
    check("t2_n7_count", {29'd0, count}, 32'd3);
    check("t2_n7_en", {31'd0, req_en}, 32'd1);
    check("t2_n7_addr", req_addr, 32'h10);
    tick();
    check("t2_n8_pc", instr_pc, 32'h8);
    tick();
    check("t2_n9_pc", instr_pc, 32'hC);
    tick();
    check("t2_n10_pc", instr_pc, 32'h10);
    check("t2_n10_data", instr_data, 32'h4);

    // ---- Test 3: redirect with 3 queued and 1 in flight ----
    do_reset(1'b0);
    tick(); tick(); tick(); tick();
    check("t3_pre_count", {29'd0, count}, 32'd3);
    redirect_en = 1'b1; redirect_addr = 32'h100; #1;
    check("t3_redir_en", {31'd0, req_en}, 32'd0);
    @(negedge clk);
    redirect_en = 1'b0; instr_ready = 1'b1; #1;
    check("t3_count", {29'd0, count}, 32'd0);
    check("t3_valid", {31'd0, instr_valid}, 32'd0);
    check("t3_addr", req_addr, 32'h100);
    check("t3_en", {31'd0, req_en}, 32'd1);
    tick();
    check("t3_n6_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    check("t3_n7_pc", instr_pc, 32'h100);
    check("t3_n7_data", instr_data, 32'h40);
    tick();
    check("t3_n8_pc", instr_pc, 32'h104);

    // ---- Test 6: asynchronous reset mid-cycle ----
    do_reset(1'b0);
    tick(); tick(); tick();
    check("t6_pre_count", {29'd0, count}, 32'd2);
    #2;
    aresetn = 1'b0;
    #1;
    check("t6_valid", {31'd0, instr_valid}, 32'd0);
    check("t6_count", {29'd0, count}, 32'd0);
    check("t6_en", {31'd0, req_en}, 32'd0);
    check("t6_data", instr_data, 32'd0);
    check("t6_pc", instr_pc, 32'd0);
    check("t6_addr", req_addr, 32'h0);
    @(negedge clk);
    aresetn = 1'b1; #1;
    check("t6_rel_en", {31'd0, req_en}, 32'd1);
    check("t6_rel_addr", req_addr, 32'h0);
    tick();
    tick();
    check("t6_rel_pc", instr_pc, 32'h0);
    check("t6_rel_valid", {31'd0, instr_valid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch stage between the synchronous instruction memory and the pipeline decode stage.
- Owns the fetch PC, issues word requests to instruction memory and buffers returned words with their PCs in a small FIFO.
- Presents words to decode over a valid/ready handshake and flushes on branch/jump redirect.

Parameters:
ADDR_W, 32, byte address width
WORD_W, 32, instruction word width
DEPTH, 4, FIFO entries (power of two, >= 2)
RESET_PC, 0, fetch address after reset (bits [1:0] must be 0)

Ports:
clk  in  1  clock, rising edge
aresetn  in  1  asynchronous active-low reset
o_instr_req_addr  out  ADDR_W  byte address of fetch request
o_instr_req_en  out  1  fetch request this cycle
i_instr_res_data  in  WORD_W  instruction word, valid the cycle after o_instr_req_en
i_redirect_en  in  1  flush and redirect fetch
i_redirect_addr  in  ADDR_W  new fetch address
o_instr_valid  out  1  head entry valid
o_instr_data  out  WORD_W  head instruction word
o_instr_pc  out  ADDR_W  head instruction PC
i_instr_ready  in  1  decode accepts head
o_count  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC, FIFO empty, in-flight flag 0. While aresetn=0, o_instr_req_en=0, o_instr_valid=0, o_count=0, o_instr_data=0, o_instr_pc=0, o_instr_req_addr=RESET_PC.
- o_instr_req_addr = fetch_pc, always word aligned.
- o_instr_req_en = aresetn && !i_redirect_en && (count + inflight < DEPTH). This credit rule guarantees the FIFO never overflows.
- On request: fetch_pc <= fetch_pc+4, wrapping modulo 2^ADDR_W. inflight <= 1 and inflight_pc <= fetch_pc. If no request that cycle, inflight <= 0.
- Cycle after a request: push {i_instr_res_data, inflight_pc} into the FIFO, unless a redirect occurred in the request cycle or in this cycle.
- Pop when o_instr_valid && i_instr_ready.
  - Push and pop in the same cycle: count unchanged.
  - Pop with FIFO empty cannot happen, because o_instr_valid=0.
- o_instr_valid = (count != 0). Head outputs hold stable while valid && !ready.
- Redirect (i_redirect_en=1):
  - Next edge: FIFO cleared (count=0), inflight cleared, and any response arriving that cycle is discarded.
  - fetch_pc <= {i_redirect_addr[ADDR_W-1:2], 2'b00}.
  - No request in the redirect cycle; the first request at the new address is issued the following cycle.
- Redirect with a simultaneous pop: the handshake completes (decode consumed the word), then the flush applies.
- Redirect takes priority over push.
- Back-to-back redirects: the last one wins.
- Latency (macro off): request issued in cycle N, memory data in N+1, o_instr_valid in N+2.
- Steady-state throughput with i_instr_ready=1: one word per cycle.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When the FIFO is empty and a valid (non-discarded) response arrives, it is presented combinationally on o_instr_valid/o_instr_data/o_instr_pc in the same cycle.
  - If accepted (i_instr_ready=1), it is not written to the FIFO. If not accepted, it is pushed normally.
  - o_count excludes the bypassed word.
  - Latency becomes request N, valid N+1.
- Undefined: all responses go through the FIFO; latency is N+2 as above.

Test Plan:
1. Reset release, i_instr_ready=1, imem word[k]=k: requests at 0x0,0x4,0x8,... on consecutive cycles. First o_instr_valid 2 cycles after the first request, with pc 0x0 and data 0. Then one word per cycle, pc +4 each.
2. i_instr_ready=0 from reset: exactly 4 requests (0x0-0xC) issued, then o_instr_req_en=0 with o_count=4. Head holds pc 0x0. Raising ready drains pcs 0x0,0x4,0x8,0xC in order, and requests resume at 0x10.
3. With 3 entries queued and one in flight, pulse i_redirect_en with addr 0x100: next cycle o_count=0, o_instr_valid=0, in-flight word never appears. Next request is addr 0x100, and the first delivered pc is 0x100.
4. Redirect in the same cycle as a pop of pc 0x8: pc 0x8 is accepted once. Queue empty the next cycle, and no pc 0xC is delivered afterwards.
5. Redirect to 0x103: request address 0x100 and delivered pc 0x100. Separately, fetch_pc=0xFFFFFFFC wraps so the next request is 0x0.
6. Assert aresetn=0 mid-cycle with 2 entries queued: o_instr_valid, o_count and o_instr_req_en go to 0 immediately without a clock edge. After release, the first request is at RESET_PC.
